// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock, optional signed mode
module seq_divider #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] part, part_n, acc, acc_n, dvs, dvs_n, quotient_n, remainder_n;
    logic neg_q, neg_q_n, neg_r, neg_r_n, busy_n, done_n, dbz_n, sa, sb, ge;
    logic [WIDTH:0] p_sh, diff;
    // acc starts as the dividend magnitude and fills with quotient bits as dividend bits shift out
    always_comb begin
        sa          = SIGNED && dividend[WIDTH-1];
        sb          = SIGNED && divisor[WIDTH-1];
        p_sh        = {part, acc[WIDTH-1]};
        diff        = p_sh - {1'b0, dvs};
        ge          = !diff[WIDTH];
        state_n     = state;
        cnt_n       = cnt;
        part_n      = part;
        acc_n       = acc;
        dvs_n       = dvs;
        neg_q_n     = neg_q;
        neg_r_n     = neg_r;
        busy_n      = busy;
        done_n      = 1'b0;
        quotient_n  = quotient;
        remainder_n = remainder;
        dbz_n       = div_by_zero;
        if (state == IDLE) begin
            if (start && divisor == '0) begin
                done_n      = 1'b1;
                quotient_n  = '0;
                remainder_n = dividend;
                dbz_n       = 1'b1;
            end else if (start) begin
                state_n = RUN;
                busy_n  = 1'b1;
                cnt_n   = CW'(WIDTH);
                part_n  = '0;
                acc_n   = sa ? -dividend : dividend;
                dvs_n   = sb ? -divisor : divisor;
                neg_q_n = sa ^ sb;
                neg_r_n = sa;
            end
        end else begin
            part_n = ge ? diff[WIDTH-1:0] : p_sh[WIDTH-1:0];
            acc_n  = {acc[WIDTH-2:0], ge};
            cnt_n  = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state_n     = IDLE;
                busy_n      = 1'b0;
                done_n      = 1'b1;
                dbz_n       = 1'b0;
                quotient_n  = neg_q ? -acc_n : acc_n;
                remainder_n = neg_r ? -part_n : part_n;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            part        <= '0;
            acc         <= '0;
            dvs         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            part        <= part_n;
            acc         <= acc_n;
            dvs         <= dvs_n;
            neg_q       <= neg_q_n;
            neg_r       <= neg_r_n;
            busy        <= busy_n;
            done        <= done_n;
            quotient    <= quotient_n;
            remainder   <= remainder_n;
            div_by_zero <= dbz_n;
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: three divider instances (8u, 8s, 16u) checked every cycle against an arithmetic model
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic st[3];
    logic [31:0] av[3], bv[3];
    logic bsy[3], dn[3], zv[3];
    logic [31:0] qv[3], rv[3];
    int checks = 0, errors = 0;

    logic b0, d0, z0, b1, d1, z1, b2, d2, z2;
    logic [7:0] q0, r0, q1, r1;
    logic [15:0] q2, r2;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(8), .SIGNED(1'b0)) u0 (.clk(clk), .rst(rst), .start(st[0]),
        .dividend(av[0][7:0]), .divisor(bv[0][7:0]), .busy(b0), .done(d0),
        .quotient(q0), .remainder(r0), .div_by_zero(z0));
    seq_divider #(.WIDTH(8), .SIGNED(1'b1)) u1 (.clk(clk), .rst(rst), .start(st[1]),
        .dividend(av[1][7:0]), .divisor(bv[1][7:0]), .busy(b1), .done(d1),
        .quotient(q1), .remainder(r1), .div_by_zero(z1));
    seq_divider #(.WIDTH(16), .SIGNED(1'b0)) u2 (.clk(clk), .rst(rst), .start(st[2]),
        .dividend(av[2][15:0]), .divisor(bv[2][15:0]), .busy(b2), .done(d2),
        .quotient(q2), .remainder(r2), .div_by_zero(z2));

    assign bsy[0] = b0; assign dn[0] = d0; assign zv[0] = z0; assign qv[0] = 32'(q0); assign rv[0] = 32'(r0);
    assign bsy[1] = b1; assign dn[1] = d1; assign zv[1] = z1; assign qv[1] = 32'(q1); assign rv[1] = 32'(r1);
    assign bsy[2] = b2; assign dn[2] = d2; assign zv[2] = z2; assign qv[2] = 32'(q2); assign rv[2] = 32'(r2);

    function automatic int wof(int i);
        return (i == 2) ? 16 : 8;
    endfunction
    function automatic bit sof(int i);
        return i == 1;
    endfunction
    function automatic logic [31:0] mk(int i);
        return 32'((64'd1 << wof(i)) - 64'd1);
    endfunction

    // truncating division on the operands' integer values, results wrapped to the instance width
    function automatic void ref_div(int i, logic [31:0] a, logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint x, y, m;
        int w;
        w = wof(i);
        m = (longint'(1) << w) - 1;
        x = longint'(a) & m;
        y = longint'(b) & m;
        if (sof(i)) begin
            if (x[w-1]) x = x - (longint'(1) << w);
            if (y[w-1]) y = y - (longint'(1) << w);
        end
        q = 32'((x / y) & m);
        r = 32'((x % y) & m);
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    // model: an accepted op completes after exactly WIDTH busy cycles
    int m_left[3];
    logic m_busy[3], m_done[3], m_z[3];
    logic [31:0] m_q[3], m_r[3], m_pq[3], m_pr[3], m_pa[3], m_pb[3];
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_left[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_z[i] = 0;
                m_q[i] = 0; m_r[i] = 0; m_pa[i] = 0; m_pb[i] = 0;
            end else begin
                m_done[i] = 0;
                if (m_left[i] > 0) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_busy[i] = 0; m_done[i] = 1; m_z[i] = 0;
                        m_q[i] = m_pq[i]; m_r[i] = m_pr[i];
                    end
                end else if (st[i]) begin
                    m_pa[i] = av[i] & mk(i);
                    m_pb[i] = bv[i] & mk(i);
                    if (m_pb[i] == 0) begin
                        m_done[i] = 1; m_q[i] = 0; m_r[i] = m_pa[i]; m_z[i] = 1;
                    end else begin
                        m_busy[i] = 1; m_left[i] = wof(i);
                        ref_div(i, m_pa[i], m_pb[i], m_pq[i], m_pr[i]);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(m_busy[i]));
            chk($sformatf("done[%0d]", i), 32'(dn[i]), 32'(m_done[i]));
            chk($sformatf("quotient[%0d]", i), qv[i], m_q[i]);
            chk($sformatf("remainder[%0d]", i), rv[i], m_r[i]);
            chk($sformatf("div_by_zero[%0d]", i), 32'(zv[i]), 32'(m_z[i]));
            chk($sformatf("busy_and_done[%0d]", i), 32'(bsy[i] & dn[i]), 32'd0);
            if (dn[i] && !zv[i] && !sof(i)) begin
                chk($sformatf("invariant_eq[%0d]", i), (qv[i] * m_pb[i] + rv[i]) & mk(i), m_pa[i]);
                chk($sformatf("invariant_lt[%0d]", i), 32'(rv[i] < m_pb[i]), 32'd1);
            end
        end
    end

    task automatic op(int i, logic [31:0] a, logic [31:0] b);
        #1;
        st[i] = 1'b1; av[i] = a; bv[i] = b;
        @(posedge clk);
        #1 st[i] = 1'b0;
    endtask

    task automatic wait_done(int i, output int nb);
        bit ok;
        nb = 0;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dn[i]) begin
                ok = 1;
                break;
            end
            if (bsy[i]) nb++;
        end
        chk("done_arrives", 32'(ok), 32'd1);
    endtask

    task automatic run(int i, logic [31:0] a, logic [31:0] b, logic [31:0] eq, logic [31:0] er,
                       logic ez, int eb, string n);
        int nb;
        op(i, a, b);
        wait_done(i, nb);
        chk({n, "_busy_cycles"}, 32'(nb), 32'(eb));
        chk({n, "_q"}, qv[i], eq);
        chk({n, "_r"}, rv[i], er);
        chk({n, "_dbz"}, 32'(zv[i]), 32'(ez));
    endtask

    initial begin
        int nb;
        for (int i = 0; i < 3; i++) begin
            st[i] = 0; av[i] = 0; bv[i] = 0;
        end
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(b0), 32'd0);
        chk("reset_q", qv[0], 32'd0);
        chk("reset_r", rv[0], 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        run(0, 200, 7, 28, 4, 0, 8, "u200_7");
        @(negedge clk);
        run(0, 93, 0, 0, 93, 1, 0, "u93_0");
        @(negedge clk);
        run(0, 255, 1, 255, 0, 0, 8, "u255_1");
        run(0, 5, 9, 0, 5, 0, 8, "u5_9_b2b");
        repeat (3) @(negedge clk);
        chk("hold_q", qv[0], 32'd0);
        chk("hold_r", rv[0], 32'd5);
        op(0, 100, 3);
        repeat (2) @(negedge clk);
        op(0, 50, 5);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(b0), 32'd0);
        chk("abort_q", qv[0], 32'd0);
        chk("abort_r", rv[0], 32'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("no_done_after_abort", 32'(d0), 32'd0);
        end
        run(0, 100, 3, 33, 1, 0, 8, "u100_3");
        @(negedge clk);
        run(1, 32'hF9, 2, 32'hFD, 32'hFF, 0, 8, "s_m7_2");
        @(negedge clk);
        run(1, 7, 32'hFE, 32'hFD, 1, 0, 8, "s7_m2");
        @(negedge clk);
        run(1, 32'h80, 32'hFF, 32'h80, 0, 0, 8, "s_m128_m1");
        @(negedge clk);
        run(2, 50000, 7, 7142, 6, 0, 16, "u16_50000_7");
        repeat (30000) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                st[i] = ($urandom % 3) == 0;
                av[i] = $urandom;
                case ($urandom % 4)
                    0: bv[i] = (($urandom % 4) == 0) ? 32'd0 : 32'($urandom % 20);
                    1: bv[i] = 32'($urandom % 300);
                    default: bv[i] = $urandom;
                endcase
            end
        end
        #1;
        for (int i = 0; i < 3; i++) st[i] = 0;
        repeat (20) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
